riscv_idu_issue_ctl: RTL and testbench
======================================

# riscv_idu_issue_ctl

Issue controller between the instruction fetch unit (IFU) and the instruction decode unit (IDU) output stage. It buffers fetched instructions in a small FIFO. It applies valid/ready handshakes on both sides and marks each instruction with an opcode-legality flag. It stamps every dispatched instruction with a contiguous 64-bit sequence number and discards all in-flight instructions on a pipeline flush.

## Interface
- DEPTH, 2, FIFO entries; power of two, ≥2
- SEQ_W, 64, sequence counter width
- clock  in  1  clock; all state changes on the rising edge
- reset  in  1  reset, synchronous, active-high
- ifu_vld  in  1  fetch instruction valid
- ifu_rdy  out  1  controller can accept a fetch instruction
- ifu_addr  in  32  fetch PC
- ifu_data  in  32  fetch instruction word
- flush  in  1  discard all buffered instructions this cycle
- idu_vld  out  1  decoded instruction valid
- idu_rdy  in  1  downstream accepts the instruction
- idu_seq  out  SEQ_W  sequence number of the presented instruction
- idu_addr  out  32  PC of the presented instruction
- idu_data  out  32  instruction word
- idu_defined  out  1  opcode is legal RV32I
- occupancy  out  $clog2(DEPTH+1)  number of valid FIFO entries

## Operation
- Enqueue fires on ifu_vld && ifu_rdy. Dispatch fires on idu_vld && idu_rdy.
- ifu_rdy = (state==RUN) && (count<DEPTH) && !flush && !reset.
  - When the FIFO is full, ifu_rdy is 0 even if a dispatch fires in the same cycle. This keeps the combinational path from idu_rdy to ifu_rdy out.
- idu_vld = (state==RUN) && (count>0) && !flush.
- FIFO is in-order and uses head/tail pointers of width $clog2(DEPTH) that wrap modulo DEPTH.
- Enqueue and dispatch in the same cycle: count is unchanged, both pointers advance.
- idu_defined is set for ifu_data[1:0]==2'b11 with ifu_data[6:2] in {LOAD, MISC_MEM, OP_IMM, AUIPC, STORE, OP, LUI, BRANCH, JALR, JAL, SYSTEM}. It is computed at enqueue and stored with the entry.
- Sequence counter:
  - Resets to 0.
  - idu_seq always shows the counter value.
  - Increments by 1 on each dispatch and wraps from 2^SEQ_W−1 to 0.
  - Flushed instructions never consume a number.
- While idu_vld=0, idu_addr, idu_data and idu_defined are driven to 0. idu_seq still shows the counter.
- FSM:
  - States: RUN and RECOVER.
  - RUN → RECOVER when flush=1.
  - RECOVER → RUN unconditionally after 1 cycle.
  - In RECOVER, ifu_rdy=0 and idu_vld=0.
  - A flush while already in RECOVER keeps the FSM in RECOVER for one more cycle.
- Flush cycle:
  - No enqueue and no dispatch fire.
  - count, head and tail are cleared at the edge.
  - The sequence counter is unchanged.
- Reset:
  - Applies in any cycle, including mid-stream and mid-flush.
  - Clears the FIFO and sets the sequence counter to 0 and the FSM to RUN.
  - Reset takes priority over flush.

## Timing
- Output values during and directly after reset: ifu_rdy=0 while reset=1. idu_vld=0, idu_seq=0, idu_addr=0, idu_data=0, idu_defined=0, occupancy=0.
- The first cycle after reset deasserts has ifu_rdy=1.
- Enqueue to idu_vld latency is 1 cycle when RISCV_IDU_BYPASS_EN is off.
- Throughput is 1 instruction per cycle once the FIFO is non-empty and idu_rdy=1.
- Once idu_vld=1, outputs are held stable until dispatch or flush.
- Flush to next possible enqueue is 2 cycles (flush cycle plus RECOVER).
- occupancy is registered and reflects count after the last edge.

## Configuration
- RISCV_IDU_BYPASS_EN defined:
  - When state==RUN, count==0 and ifu_vld=1, the incoming instruction is presented on idu_vld/idu_addr/idu_data/idu_defined in the same cycle.
  - If idu_rdy=1, it dispatches without being stored: seq increments and count stays 0. Otherwise it is enqueued normally.
  - Latency is 0 cycles.
- RISCV_IDU_BYPASS_EN undefined: no combinational ifu→idu path; latency is always 1 cycle.

## Structure
- riscv_pkg holds:
  - RV32I opcode localparams (OPC_LOAD … OPC_SYSTEM).
  - A typedef for the FIFO entry struct {addr[31:0], data[31:0], defined}.
  - A typedef for the FSM enum {RUN, RECOVER}.
- One sub-module: riscv_opcode_legal, a combinational decode from the 32-bit word to the defined flag.
- FIFO storage stays inline in this module.

## Test plan
- Reset, then IFU sends addr 0x0/0x4/0x8 with data 0x00000013 and idu_rdy=1. Expect idu_seq 0, 1, 2 on consecutive cycles, idu_defined=1, and 1-cycle latency with bypass off.
- idu_rdy=0 with 3 instructions offered, DEPTH=2. Expect ifu_rdy=0 after 2 enqueues and occupancy=2. After idu_rdy=1, they drain in order with seq 0, 1.
- data=0x00000000 is enqueued. Expect idu_defined=0. data=0x0000006F (JAL) gives idu_defined=1.
- Full FIFO, then flush pulse. Expect idu_vld=0 in the flush cycle and the next cycle, occupancy=0, ifu_rdy=1 two cycles after flush, and the next dispatch reuses the unconsumed seq value.
- Sequence counter forced to 2^64−1 via a SEQ_W=64 long run or backdoor preload. Expect idu_seq 0xFFFFFFFFFFFFFFFF, then 0.
- Bypass build, empty FIFO, ifu_vld=1 and idu_rdy=1 in the same cycle. Expect idu_vld=1 that cycle with the matching addr/data and occupancy staying 0.

Source files
------------

// File: rtl/riscv_idu_issue_ctl_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
//   Shared definitions for the IFU -> IDU issue controller:
//     - RV32I major opcode values (instr[6:2])
//     - fifo_entry_t : one buffered instruction {addr, data, defined}
//     - issue_state_t: issue FSM states {RUN, RECOVER}
//   No ports (package only).
// ---------------------------------------------------------------------------
package riscv_pkg;

  // RV32I major opcodes, i.e. instr[6:2] of a 32-bit encoding (instr[1:0]==2'b11)
  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  // One buffered instruction; the legality flag is resolved at enqueue time
  // so the dispatch side never has to decode.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        defined;
  } fifo_entry_t;

  // RECOVER is the single bubble cycle that follows a flush.
  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } issue_state_t;

endpackage : riscv_pkg

// File: rtl/riscv_idu_issue_ctl_if.sv
// ---------------------------------------------------------------------------
// riscv_idu_issue_ctl_if
//   Handshake bundle between fetch (IFU), the issue controller and the decode
//   output stage (IDU).
//   Signals:
//     ifu_vld / ifu_rdy         fetch-side valid/ready
//     ifu_addr / ifu_data       fetch PC and instruction word
//     idu_vld / idu_rdy         decode-side valid/ready
//     idu_seq                   sequence number of the presented instruction
//     idu_addr / idu_data       presented PC and instruction word
//     idu_defined               presented opcode is legal RV32I
//   Modports:
//     slave  - the issue controller
//     master - the environment driving fetch and consuming decode
// ---------------------------------------------------------------------------
interface riscv_idu_issue_ctl_if #(
  parameter int SEQ_W = 64
);

  logic             ifu_vld;
  logic             ifu_rdy;
  logic [31:0]      ifu_addr;
  logic [31:0]      ifu_data;

  logic             idu_vld;
  logic             idu_rdy;
  logic [SEQ_W-1:0] idu_seq;
  logic [31:0]      idu_addr;
  logic [31:0]      idu_data;
  logic             idu_defined;

  modport slave (
    input  ifu_vld, ifu_addr, ifu_data, idu_rdy,
    output ifu_rdy, idu_vld, idu_seq, idu_addr, idu_data, idu_defined
  );

  modport master (
    output ifu_vld, ifu_addr, ifu_data, idu_rdy,
    input  ifu_rdy, idu_vld, idu_seq, idu_addr, idu_data, idu_defined
  );

endinterface : riscv_idu_issue_ctl_if

// File: rtl/riscv_idu_issue_ctl_opcode_legal.sv
// ---------------------------------------------------------------------------
// riscv_opcode_legal
//   Combinational RV32I major-opcode legality check.
//   Ports:
//     i_opcode  [6:0]  low 7 bits of the instruction word
//     o_defined        1 when the word is a 32-bit encoding with an RV32I
//                      major opcode
//   Only the opcode field is needed, so the caller passes just instr[6:0].
// ---------------------------------------------------------------------------
module riscv_opcode_legal
  import riscv_pkg::*;
(
  input  logic [6:0] i_opcode,
  output logic       o_defined
);

  // Compressed/other-length encodings (instr[1:0] != 2'b11) are never legal
  // here; otherwise the major opcode must be one of the eleven RV32I groups.
  always_comb begin
    o_defined = 1'b0;
    if (i_opcode[1:0] == 2'b11) begin
      case (i_opcode[6:2])
        OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
        OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: o_defined = 1'b1;
        default:                                            o_defined = 1'b0;
      endcase
    end
  end

endmodule : riscv_opcode_legal

// File: rtl/riscv_idu_issue_ctl.sv
// ---------------------------------------------------------------------------
// riscv_idu_issue_ctl
//   Issue controller between fetch and the decode output stage. Buffers
//   fetched instructions in an in-order FIFO, tags each with an RV32I opcode
//   legality flag, stamps every dispatched instruction with a contiguous
//   sequence number and drops everything in flight on a flush.
//
//   Parameters:
//     DEPTH  FIFO entries (power of two, >= 2)
//     SEQ_W  sequence counter width
//   Ports:
//     clock      rising-edge clock
//     reset      synchronous, active-high; wins over flush
//     flush      discard all buffered instructions this cycle
//     bus        riscv_idu_issue_ctl_if.slave (IFU and IDU handshakes)
//     occupancy  registered count of valid FIFO entries
//
//   Build option:
//     RISCV_IDU_BYPASS_EN  when defined, an instruction arriving at an empty
//                          FIFO in RUN is presented to the IDU in the same
//                          cycle (0-cycle latency) and, if accepted, is never
//                          written into the FIFO. When undefined there is no
//                          combinational fetch-to-decode path.
// ---------------------------------------------------------------------------
module riscv_idu_issue_ctl
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int SEQ_W = 64
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  riscv_idu_issue_ctl_if.slave         bus,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  issue_state_t     r_state;
  issue_state_t     w_stateNext;
  fifo_entry_t      r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [SEQ_W-1:0] r_seq;

  logic        w_defined;
  fifo_entry_t w_inEntry;
  fifo_entry_t w_headEntry;
  logic        w_ifuRdy;
  logic        w_fifoValid;
  logic        w_bypass;
  logic        w_iduVld;
  logic        w_enq;
  logic        w_deq;
  logic        w_bypassFire;
  logic        w_store;
  logic        w_pop;

  // Legality is decoded once on the way in and stored with the entry.
  riscv_opcode_legal u_opcodeLegal (
    .i_opcode  (bus.ifu_data[6:0]),
    .o_defined (w_defined)
  );

  // Incoming entry assembled from the fetch bus plus its legality flag.
  always_comb begin
    w_inEntry         = '0;
    w_inEntry.addr    = bus.ifu_addr;
    w_inEntry.data    = bus.ifu_data;
    w_inEntry.defined = w_defined;
  end

  assign w_headEntry = r_mem[r_head];

  // Fetch is refused while full even if a dispatch frees a slot this cycle,
  // so idu_rdy never reaches ifu_rdy combinationally.
  assign w_ifuRdy = (r_state == RUN) && (r_count < FULL_CNT) && !flush && !reset;

  // Head-of-FIFO presentation; reset also masks it so outputs read as idle
  // for the whole reset window.
  assign w_fifoValid = (r_state == RUN) && (r_count != '0) && !flush && !reset;

`ifdef RISCV_IDU_BYPASS_EN
  // Empty FIFO in RUN: forward the fetch bus straight to decode.
  assign w_bypass = (r_state == RUN) && (r_count == '0) && bus.ifu_vld && !flush && !reset;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_iduVld     = w_fifoValid || w_bypass;
  assign w_enq        = bus.ifu_vld && w_ifuRdy;
  assign w_deq        = w_iduVld && bus.idu_rdy;
  // A bypassed instruction that is accepted immediately never occupies a slot.
  assign w_bypassFire = w_bypass && bus.idu_rdy;
  assign w_store      = w_enq && !w_bypassFire;
  assign w_pop        = w_deq && w_fifoValid;

  // Decode-side outputs: head entry, else the bypassed fetch, else all zero.
  // The sequence number is always visible, independent of idu_vld.
  always_comb begin
    bus.idu_addr    = '0;
    bus.idu_data    = '0;
    bus.idu_defined = 1'b0;
    if (w_fifoValid) begin
      bus.idu_addr    = w_headEntry.addr;
      bus.idu_data    = w_headEntry.data;
      bus.idu_defined = w_headEntry.defined;
    end else if (w_bypass) begin
      bus.idu_addr    = w_inEntry.addr;
      bus.idu_data    = w_inEntry.data;
      bus.idu_defined = w_inEntry.defined;
    end
  end

  assign bus.ifu_rdy = w_ifuRdy;
  assign bus.idu_vld = w_iduVld;
  assign bus.idu_seq = r_seq;
  assign occupancy   = r_count;

  // Entry storage carries no reset: validity is tracked purely by r_count,
  // so stale contents are never observable.
  always_ff @(posedge clock) begin
    if (w_store) begin
      r_mem[r_tail] <= w_inEntry;
    end
  end

  // Pointers, count and sequence number. Flush empties the FIFO but keeps
  // the sequence number, so dropped instructions never consume a value.
  // Pointers are exactly PTR_W bits, so wrap modulo DEPTH is free.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_seq   <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_store) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      if (w_store && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_store) begin
        r_count <= r_count - CNT_W'(1);
      end
      if (w_deq) begin
        r_seq <= r_seq + SEQ_W'(1);
      end
    end
  end

  // FSM state register; reset lands in RUN even if flush is also high.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // A flush always leads to one RECOVER bubble; a flush during RECOVER
  // extends it by another cycle.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      RUN:     if (flush) w_stateNext = RECOVER;
      RECOVER: w_stateNext = flush ? RECOVER : RUN;
      default: w_stateNext = RUN;
    endcase
  end

endmodule : riscv_idu_issue_ctl

// File: tb/tb_riscv_idu_issue_ctl.sv
// ---------------------------------------------------------------------------
// tb_riscv_idu_issue_ctl
//   Scoreboard bench for riscv_idu_issue_ctl. The stimulus process pushes the
//   expected instruction whenever it sees a fetch accepted; an independent
//   monitor pops and compares on every dispatch, tracking its own expected
//   sequence number. A second instance with SEQ_W=4 exercises counter wrap.
// ---------------------------------------------------------------------------
module tb_riscv_idu_issue_ctl;

`ifdef RISCV_IDU_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic       flush;
  logic       resetW;
  logic       flushW;
  logic [1:0] occupancy;
  logic [1:0] occW;

  riscv_idu_issue_ctl_if #(.SEQ_W(64)) busA ();
  riscv_idu_issue_ctl_if #(.SEQ_W(4))  busW ();

  riscv_idu_issue_ctl #(.DEPTH(2), .SEQ_W(64)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .bus       (busA),
    .occupancy (occupancy)
  );

  riscv_idu_issue_ctl #(.DEPTH(2), .SEQ_W(4)) dutW (
    .clock     (clock),
    .reset     (resetW),
    .flush     (flushW),
    .bus       (busW),
    .occupancy (occW)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        defined;
  } exp_t;

  exp_t        expQ[$];
  logic [63:0] expSeq;
  int          testsRun    = 0;
  int          testsFailed = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One clock of stimulus on the main instance. Inputs change just after the
  // rising edge; handshake state is sampled on the falling edge.
  task automatic applyStimulus(input logic vld, input logic [31:0] a,
                               input logic [31:0] d, input logic expDef,
                               input logic rdy, input logic fl,
                               output logic sRdy, output logic sVld,
                               output logic [1:0] sOcc);
    busA.ifu_vld  = vld;
    busA.ifu_addr = a;
    busA.ifu_data = d;
    busA.idu_rdy  = rdy;
    flush         = fl;
    @(negedge clock);
    sRdy = busA.ifu_rdy;
    sVld = busA.idu_vld;
    sOcc = occupancy;
    if (vld && busA.ifu_rdy) expQ.push_back('{a, d, expDef});
    if (fl) expQ.delete();
    @(posedge clock);
    #1;
  endtask

  task automatic resetDut(input logic fl);
    reset         = 1'b1;
    flush         = fl;
    busA.ifu_vld  = 1'b0;
    busA.ifu_addr = '0;
    busA.ifu_data = '0;
    busA.idu_rdy  = 1'b0;
    @(posedge clock);
    @(negedge clock);
    checkOutput("rstIfuRdy",  busA.ifu_rdy, 0);
    checkOutput("rstIduVld",  busA.idu_vld, 0);
    checkOutput("rstSeq",     busA.idu_seq, 0);
    checkOutput("rstAddr",    busA.idu_addr, 0);
    checkOutput("rstData",    busA.idu_data, 0);
    checkOutput("rstDefined", busA.idu_defined, 0);
    checkOutput("rstOcc",     occupancy, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    flush = 1'b0;
    expQ.delete();
    @(negedge clock);
    checkOutput("postRstIfuRdy", busA.ifu_rdy, 1);
    @(posedge clock);
    #1;
  endtask

  // Scoreboard monitor: compares every dispatch against the queue head and
  // checks that idle outputs read as zero.
  initial begin
    exp_t e;
    expSeq = '0;
    forever begin
      @(negedge clock);
      #1;
      if (reset) begin
        expSeq = '0;
      end else if (busA.idu_vld) begin
        if (busA.idu_rdy) begin
          if (expQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL unexpectedDispatch: got addr 0x%0h, expected no dispatch",
                     busA.idu_addr);
          end else begin
            e = expQ.pop_front();
            checkOutput("dispAddr",    busA.idu_addr, e.addr);
            checkOutput("dispData",    busA.idu_data, e.data);
            checkOutput("dispDefined", busA.idu_defined, e.defined);
            checkOutput("dispSeq",     busA.idu_seq, expSeq);
          end
          expSeq = expSeq + 64'd1;
        end
      end else begin
        checkOutput("idleAddr",    busA.idu_addr, 0);
        checkOutput("idleData",    busA.idu_data, 0);
        checkOutput("idleDefined", busA.idu_defined, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic       sRdy;
    logic       sVld;
    logic [1:0] sOcc;
    logic [3:0] expW;
    int         nW;

    reset  = 1'b1;
    flush  = 1'b0;
    resetW = 1'b1;
    flushW = 1'b0;
    busW.ifu_vld  = 1'b0;
    busW.ifu_addr = '0;
    busW.ifu_data = '0;
    busW.idu_rdy  = 1'b0;

    // Three back-to-back ADDI fetches with decode always ready.
    resetDut(1'b0);
    applyStimulus(1, 32'h0, 32'h00000013, 1, 1, 0, sRdy, sVld, sOcc);
    checkOutput("s1VldA", sVld, BYP);
    applyStimulus(1, 32'h4, 32'h00000013, 1, 1, 0, sRdy, sVld, sOcc);
    checkOutput("s1VldB", sVld, 1);
    applyStimulus(1, 32'h8, 32'h00000013, 1, 1, 0, sRdy, sVld, sOcc);
    checkOutput("s1VldC", sVld, 1);
    applyStimulus(0, 32'h0, 32'h0, 0, 1, 0, sRdy, sVld, sOcc);
    checkOutput("s1VldTail", sVld, !BYP);
    applyStimulus(0, 32'h0, 32'h0, 0, 1, 0, sRdy, sVld, sOcc);
    checkOutput("s1VldIdle", sVld, 0);
    checkOutput("s1Seq", busA.idu_seq, 3);

    // Backpressure: fill DEPTH=2, third fetch stalls, then drain in order.
    resetDut(1'b0);
    applyStimulus(1, 32'h100, 32'h00000013, 1, 0, 0, sRdy, sVld, sOcc);
    checkOutput("s2RdyA", sRdy, 1);
    applyStimulus(1, 32'h104, 32'h00000000, 0, 0, 0, sRdy, sVld, sOcc);
    checkOutput("s2RdyB", sRdy, 1);
    applyStimulus(1, 32'h108, 32'h0000006F, 1, 0, 0, sRdy, sVld, sOcc);
    checkOutput("s2RdyFull", sRdy, 0);
    checkOutput("s2OccFull", sOcc, 2);
    checkOutput("s2VldFull", sVld, 1);
    applyStimulus(1, 32'h108, 32'h0000006F, 1, 1, 0, sRdy, sVld, sOcc);
    checkOutput("s2RdyFullDeq", sRdy, 0);
    applyStimulus(1, 32'h108, 32'h0000006F, 1, 1, 0, sRdy, sVld, sOcc);
    checkOutput("s2RdyC", sRdy, 1);
    checkOutput("s2OccOne", sOcc, 1);
    applyStimulus(0, 32'h0, 32'h0, 0, 1, 0, sRdy, sVld, sOcc);
    checkOutput("s2VldC", sVld, 1);
    applyStimulus(0, 32'h0, 32'h0, 0, 1, 0, sRdy, sVld, sOcc);
    checkOutput("s2OccEmpty", sOcc, 0);
    checkOutput("s2VldEmpty", sVld, 0);

    // Flush a full FIFO; the two dropped entries must not consume seq 3/4.
    applyStimulus(1, 32'h200, 32'h00000013, 1, 0, 0, sRdy, sVld, sOcc);
    applyStimulus(1, 32'h204, 32'h00100073, 1, 0, 0, sRdy, sVld, sOcc);
    applyStimulus(1, 32'h208, 32'h0000007F, 0, 1, 1, sRdy, sVld, sOcc);
    checkOutput("s3FlushVld", sVld, 0);
    checkOutput("s3FlushRdy", sRdy, 0);
    checkOutput("s3FlushOcc", sOcc, 2);
    applyStimulus(1, 32'h208, 32'h0000007F, 0, 1, 0, sRdy, sVld, sOcc);
    checkOutput("s3RecVld", sVld, 0);
    checkOutput("s3RecRdy", sRdy, 0);
    checkOutput("s3RecOcc", sOcc, 0);
    applyStimulus(1, 32'h208, 32'h0000007F, 0, 1, 0, sRdy, sVld, sOcc);
    checkOutput("s3RunRdy", sRdy, 1);
    checkOutput("s3RunVld", sVld, BYP);
    applyStimulus(0, 32'h0, 32'h0, 0, 1, 0, sRdy, sVld, sOcc);
    checkOutput("s3VldF", sVld, !BYP);
    applyStimulus(0, 32'h0, 32'h0, 0, 1, 0, sRdy, sVld, sOcc);
    checkOutput("s3Seq", busA.idu_seq, 4);

    // Reset with flush held high and an entry buffered: reset must win.
    applyStimulus(1, 32'h280, 32'h00000013, 1, 0, 0, sRdy, sVld, sOcc);
    resetDut(1'b1);
    applyStimulus(1, 32'h300, 32'h00000037, 1, 1, 0, sRdy, sVld, sOcc);
    checkOutput("s4RdyH", sRdy, 1);
    applyStimulus(0, 32'h0, 32'h0, 0, 1, 0, sRdy, sVld, sOcc);
    applyStimulus(0, 32'h0, 32'h0, 0, 1, 0, sRdy, sVld, sOcc);
    checkOutput("s4Seq", busA.idu_seq, 1);

    // Sequence wrap on the narrow instance: 15 must be followed by 0.
    busW.ifu_vld  = 1'b1;
    busW.ifu_data = 32'h00000013;
    busW.idu_rdy  = 1'b1;
    resetW        = 1'b0;
    expW          = 4'h0;
    nW            = 0;
    for (int i = 0; i < 20; i++) begin
      busW.ifu_addr = 32'(i * 4);
      @(negedge clock);
      if (busW.idu_vld) begin
        checkOutput("wrapSeq", busW.idu_seq, expW);
        expW = expW + 4'h1;
        nW++;
      end
      @(posedge clock);
      #1;
    end
    checkOutput("wrapCount", nW, BYP ? 20 : 19);
    checkOutput("wrapOcc", occW, BYP ? 0 : 1);

    checkOutput("queueDrained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule : tb_riscv_idu_issue_ctl
